lsu_split_access: RTL and testbench

- Initiator-side load/store unit for the single-port data memory: byte-enable/lane interface with combinational read and write on the clock edge.
- Accepts one core load/store request at a time and drives the memory's mem_write/byte_en/addr/write_data.
- Extracts and sign/zero-extends load data and returns a one-cycle response.
- Misaligned halfword/word accesses are split into two word-aligned memory cycles.

---
 rtl/lsu_pkg.sv | 44 ++++
 rtl/lsu_lane_align.sv | 49 ++++
 rtl/lsu_split_access.sv | 177 +++++++++++++++++
 tb/tb_lsu_split_access.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lsu_pkg
// Description : Shared constants, FSM state type and helper functions for the
//               split-access load/store unit.
// Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

    // RV32I load/store size and sign encodings
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC0 = 2'd1,
        ST_ACC1 = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    // Access size in bytes; illegal encodings fall through to a word so the
    // lane math stays well defined even though no access is made.
    function automatic logic [2:0] size_of(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   size_of = 3'd1;
            2'b01:   size_of = 3'd2;
            default: size_of = 3'd4;
        endcase
    endfunction

    // Unsigned variants only exist for loads.
    function automatic logic is_legal(input logic [2:0] f3, input logic we);
        case (f3)
            F3_B, F3_H, F3_W: is_legal = 1'b1;
            F3_BU, F3_HU:     is_legal = ~we;
            default:          is_legal = 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_lane_align.sv
`default_nettype none
// ============================================================================
// Module      : lsu_lane_align
// Description : Combinational byte-lane math: 8-lane enable mask across two
//               adjacent words, lane-shifted store data, and load extraction
//               with sign/zero extension.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [2:0]  f3_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] wdata_i,
    input  logic [63:0] rdata64_i,
    output logic [7:0]  mask8_o,
    output logic [63:0] wide_wdata_o,
    output logic [31:0] load_data_o
);

    logic [2:0]  w_size;
    logic [7:0]  w_base_mask;
    logic [4:0]  w_shamt;
    logic [31:0] w_v;

    // Lane mask/data shifting and load extension from the current offset
    always_comb begin
        w_size = size_of(f3_i);
        case (w_size)
            3'd1:    w_base_mask = 8'h01;
            3'd2:    w_base_mask = 8'h03;
            default: w_base_mask = 8'h0F;
        endcase
        w_shamt      = {off_i, 3'b000};
        mask8_o      = w_base_mask << off_i;
        wide_wdata_o = {32'h0, wdata_i} << w_shamt;
        w_v          = 32'(rdata64_i >> w_shamt);
        case (f3_i)
            F3_B:    load_data_o = {{24{w_v[7]}}, w_v[7:0]};
            F3_H:    load_data_o = {{16{w_v[15]}}, w_v[15:0]};
            F3_W:    load_data_o = w_v;
            F3_BU:   load_data_o = {24'h0, w_v[7:0]};
            F3_HU:   load_data_o = {16'h0, w_v[15:0]};
            default: load_data_o = 32'h0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/lsu_split_access.sv
`default_nettype none
// ============================================================================
// Module      : lsu_split_access
// Description : Initiator-side load/store unit for a single-port byte-lane
//               data memory. Accesses crossing a word boundary are split into
//               two word-aligned memory cycles (or flagged as errors).
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_split_access
    import lsu_pkg::*;
#(
    parameter bit ALLOW_MISALIGNED = 1'b1,
    parameter int ADDR_W           = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_write,
    output logic [3:0]        byte_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam logic [ADDR_W-1:0] c_WORD_STEP = ADDR_W'(4);

    state_t             state_q;
    logic               we_q;
    logic [2:0]         f3_q;
    logic [1:0]         off_q;
    logic [31:0]        wdata_q;
    logic [31:0]        lo_q;
    logic               ready_q;
    logic               resp_valid_q;
    logic [31:0]        resp_rdata_q;
    logic               resp_err_q;
    logic               mem_write_q;
    logic [3:0]         byte_en_q;
    logic [ADDR_W-1:0]  mem_addr_q;
    logic [31:0]        mem_wdata_q;

    logic               w_idle;
    logic [2:0]         w_f3;
    logic [1:0]         w_off;
    logic [31:0]        w_wdata;
    logic [63:0]        w_rd64;
    logic [7:0]         w_mask8;
    logic [63:0]        w_wide;
    logic [31:0]        w_load;
    logic               w_split;
    logic [ADDR_W-1:0]  w_base;

    // In IDLE the lane math looks at the incoming request so the first memory
    // cycle can be presented from registers right after the accept edge.
    always_comb begin
        w_idle  = (state_q == ST_IDLE);
        w_f3    = w_idle ? req_funct3     : f3_q;
        w_off   = w_idle ? req_addr[1:0]  : off_q;
        w_wdata = w_idle ? req_wdata      : wdata_q;
        w_rd64  = (state_q == ST_ACC1) ? {mem_rdata, lo_q} : {32'h0, mem_rdata};
        w_split = |w_mask8[7:4];
        w_base  = {req_addr[ADDR_W-1:2], 2'b00};
    end

    lsu_lane_align u_lane_align (
        .f3_i         (w_f3),
        .off_i        (w_off),
        .wdata_i      (w_wdata),
        .rdata64_i    (w_rd64),
        .mask8_o      (w_mask8),
        .wide_wdata_o (w_wide),
        .load_data_o  (w_load)
    );

    // Request/access/response sequencing with registered memory and core outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            we_q         <= 1'b0;
            f3_q         <= 3'b000;
            off_q        <= 2'b00;
            wdata_q      <= 32'h0;
            lo_q         <= 32'h0;
            ready_q      <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0;
            resp_err_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            byte_en_q    <= 4'b0000;
            mem_addr_q   <= '0;
            mem_wdata_q  <= 32'h0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        f3_q    <= req_funct3;
                        off_q   <= req_addr[1:0];
                        wdata_q <= req_wdata;
                        ready_q <= 1'b0;
                        if (!is_legal(req_funct3, req_we)) begin
                            state_q      <= ST_RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                            resp_rdata_q <= 32'h0;
                        end else begin
                            state_q     <= ST_ACC0;
                            mem_addr_q  <= w_base;
                            byte_en_q   <= w_mask8[3:0];
                            mem_wdata_q <= w_wide[31:0];
                            // A disallowed split must never touch memory.
                            mem_write_q <= req_we & ~(w_split & ~ALLOW_MISALIGNED);
                        end
                    end
                end
                ST_ACC0: begin
                    lo_q <= mem_rdata;
                    if (w_split && !ALLOW_MISALIGNED) begin
                        state_q      <= ST_RESP;
                        mem_write_q  <= 1'b0;
                        byte_en_q    <= 4'b0000;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b1;
                        resp_rdata_q <= 32'h0;
                    end else if (w_split) begin
                        state_q     <= ST_ACC1;
                        mem_addr_q  <= mem_addr_q + c_WORD_STEP;
                        byte_en_q   <= w_mask8[7:4];
                        mem_wdata_q <= w_wide[63:32];
                        mem_write_q <= we_q;
                    end else begin
                        state_q      <= ST_RESP;
                        mem_write_q  <= 1'b0;
                        byte_en_q    <= 4'b0000;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b0;
                        resp_rdata_q <= we_q ? 32'h0 : w_load;
                    end
                end
                ST_ACC1: begin
                    state_q      <= ST_RESP;
                    mem_write_q  <= 1'b0;
                    byte_en_q    <= 4'b0000;
                    resp_valid_q <= 1'b1;
                    resp_err_q   <= 1'b0;
                    resp_rdata_q <= we_q ? 32'h0 : w_load;
                end
                default: begin
                    state_q      <= ST_IDLE;
                    resp_valid_q <= 1'b0;
                    resp_err_q   <= 1'b0;
                    resp_rdata_q <= 32'h0;
                    ready_q      <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready  = ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign mem_write  = mem_write_q;
    assign byte_en    = byte_en_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_lsu_split_access.sv
`default_nettype none
// ============================================================================
// Module      : tb_lsu_split_access
// Description : Self-checking bench for lsu_split_access. A byte-addressed
//               reference memory predicts accesses, responses and final
//               memory contents for directed and random requests.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu_split_access;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err, mem_write;
    logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  byte_en;

    logic        req_valid2, req_ready2, req_we2;
    logic [2:0]  req_funct3_2;
    logic [31:0] req_addr2, req_wdata2;
    logic        resp_valid2, resp_err2, mem_write2;
    logic [31:0] resp_rdata2, mem_addr2, mem_wdata2;
    logic [31:0] mem_rdata2;
    logic [3:0]  byte_en2;
    logic        saw_wr2;

    logic [31:0] mem [0:63];
    logic [7:0]  ref_b [0:255];

    int          n_vec = 0;
    int          n_bad = 0;
    logic [31:0] t_rd;
    logic        t_err;
    int          t_lat;

    lsu_split_access #(.ALLOW_MISALIGNED(1'b1), .ADDR_W(32)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_write(mem_write), .byte_en(byte_en), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    lsu_split_access #(.ALLOW_MISALIGNED(1'b0), .ADDR_W(32)) dut_strict (
        .clk(clk), .reset(reset),
        .req_valid(req_valid2), .req_ready(req_ready2), .req_we(req_we2),
        .req_funct3(req_funct3_2), .req_addr(req_addr2), .req_wdata(req_wdata2),
        .resp_valid(resp_valid2), .resp_rdata(resp_rdata2), .resp_err(resp_err2),
        .mem_write(mem_write2), .byte_en(byte_en2), .mem_addr(mem_addr2),
        .mem_wdata(mem_wdata2), .mem_rdata(mem_rdata2)
    );

    // Word memory, 64 words aliased over the address space via addr[7:2]
    assign mem_rdata  = mem[mem_addr[7:2]];
    assign mem_rdata2 = 32'hDEAD_BEEF;

    always @(posedge clk) begin
        if (mem_write === 1'b1) begin
            for (int k = 0; k < 4; k++)
                if (byte_en[k]) mem[mem_addr[7:2]][8*k +: 8] <= mem_wdata[8*k +: 8];
        end
    end

    always @(posedge clk) begin
        if (reset) saw_wr2 <= 1'b0;
        else if (mem_write2 === 1'b1) saw_wr2 <= 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_word(input int w, input logic [31:0] v);
        mem[w] <= v;
        for (int k = 0; k < 4; k++) ref_b[4*w + k] = v[8*k +: 8];
    endtask

    // Issue one request to the main unit and compare it against the byte model
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, output logic [31:0] o_rd,
                          output logic o_err, output int o_lat);
        logic        legal;
        int          size, n_exp, n_obs, exp_lat, lat;
        logic [31:0] exp_a [0:1];
        logic [3:0]  exp_be [0:1];
        logic [31:0] exp_wd [0:1];
        logic [31:0] obs_a [0:1];
        logic [3:0]  obs_be [0:1];
        logic [31:0] obs_wd [0:1];
        logic        obs_wr [0:1];
        logic [31:0] raw, exp_rd, ba, wa, lmask, got_rd;
        logic        got, got_err;

        legal = (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010) ||
                (!we && (f3 == 3'b100 || f3 == 3'b101));
        size  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        n_exp = 0; raw = 32'h0; exp_rd = 32'h0;
        for (int j = 0; j < 2; j++) begin
            exp_a[j] = 32'h0; exp_be[j] = 4'h0; exp_wd[j] = 32'h0;
            obs_a[j] = 32'h0; obs_be[j] = 4'h0; obs_wd[j] = 32'h0; obs_wr[j] = 1'b0;
        end
        if (legal) begin
            for (int i = 0; i < size; i++) begin
                ba = addr + 32'(i);
                wa = {ba[31:2], 2'b00};
                if (n_exp == 0 || exp_a[n_exp-1] != wa) begin
                    exp_a[n_exp] = wa;
                    n_exp++;
                end
                exp_be[n_exp-1][ba[1:0]] = 1'b1;
                exp_wd[n_exp-1][8*ba[1:0] +: 8] = wd[8*i +: 8];
                raw[8*i +: 8] = ref_b[ba[7:0]];
            end
            if (we) begin
                for (int i = 0; i < size; i++) begin
                    ba = addr + 32'(i);
                    ref_b[ba[7:0]] = wd[8*i +: 8];
                end
            end else if (size == 1) begin
                exp_rd = f3[2] ? {24'h0, raw[7:0]} : {{24{raw[7]}}, raw[7:0]};
            end else if (size == 2) begin
                exp_rd = f3[2] ? {16'h0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
            end else begin
                exp_rd = raw;
            end
            exp_lat = n_exp + 1;
        end else begin
            exp_lat = 1;
        end

        @(negedge clk);
        chk("req_ready_idle", {31'h0, req_ready}, 32'h1);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;

        n_obs = 0; got = 1'b0; lat = 0; got_rd = 32'h0; got_err = 1'b0;
        for (int c = 1; c <= 8 && !got; c++) begin
            @(negedge clk);
            if (byte_en !== 4'h0 || mem_write !== 1'b0) begin
                if (n_obs < 2) begin
                    obs_a[n_obs] = mem_addr; obs_be[n_obs] = byte_en;
                    obs_wd[n_obs] = mem_wdata; obs_wr[n_obs] = mem_write;
                end
                n_obs++;
            end
            if (resp_valid === 1'b1) begin
                got = 1'b1; lat = c; got_rd = resp_rdata; got_err = resp_err;
            end
        end
        chk("resp_seen", {31'h0, got}, 32'h1);
        chk("latency", 32'(lat), 32'(exp_lat));
        chk("resp_err", {31'h0, got_err}, {31'h0, ~legal});
        chk("resp_rdata", got_rd, exp_rd);
        chk("access_count", 32'(n_obs), 32'(n_exp));
        for (int j = 0; j < 2; j++) begin
            if (j < n_exp && j < n_obs) begin
                chk("acc_addr", obs_a[j], exp_a[j]);
                chk("acc_be", {28'h0, obs_be[j]}, {28'h0, exp_be[j]});
                chk("acc_write", {31'h0, obs_wr[j]}, {31'h0, we});
                if (we) begin
                    for (int k = 0; k < 4; k++) lmask[8*k +: 8] = {8{exp_be[j][k]}};
                    chk("acc_wdata", obs_wd[j] & lmask, exp_wd[j]);
                end
            end
        end
        @(negedge clk);
        chk("resp_one_cycle", {31'h0, resp_valid}, 32'h0);
        o_rd = got_rd; o_err = got_err; o_lat = lat;
    endtask

    // Watchdog in case the clocked flow itself stalls
    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic [31:0] v;
        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0;
        req_addr = 32'h0; req_wdata = 32'h0;
        req_valid2 = 1'b0; req_we2 = 1'b0; req_funct3_2 = 3'b0;
        req_addr2 = 32'h0; req_wdata2 = 32'h0;
        for (int w = 0; w < 64; w++) begin
            v = $urandom;
            set_word(w, v);
        end
        set_word(0, 32'h8877_6655);
        set_word(1, 32'h4433_2211);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
        chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        chk("rst_resp_rdata", resp_rdata, 32'h0);
        chk("rst_resp_err", {31'h0, resp_err}, 32'h0);
        chk("rst_mem_write", {31'h0, mem_write}, 32'h0);
        chk("rst_byte_en", {28'h0, byte_en}, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);

        // Directed loads on the preset words
        do_req(1'b0, 3'b010, 32'h100, 32'h0, t_rd, t_err, t_lat);
        chk("lw_100_rdata", t_rd, 32'h8877_6655);
        chk("lw_100_lat", 32'(t_lat), 32'd2);
        do_req(1'b0, 3'b000, 32'h103, 32'h0, t_rd, t_err, t_lat);
        chk("lb_103_rdata", t_rd, 32'hFFFF_FF88);
        do_req(1'b0, 3'b100, 32'h103, 32'h0, t_rd, t_err, t_lat);
        chk("lbu_103_rdata", t_rd, 32'h0000_0088);
        do_req(1'b0, 3'b001, 32'h103, 32'h0, t_rd, t_err, t_lat);
        chk("lh_103_rdata", t_rd, 32'h0000_1188);
        chk("lh_103_lat", 32'(t_lat), 32'd3);

        // Split store, then memory contents
        do_req(1'b1, 3'b010, 32'h102, 32'hAABB_CCDD, t_rd, t_err, t_lat);
        chk("sw_mem_100", mem[0], 32'hCCDD_6655);
        chk("sw_mem_104", mem[1], 32'h4433_AABB);

        // Illegal encodings
        do_req(1'b0, 3'b011, 32'h100, 32'h0, t_rd, t_err, t_lat);
        chk("illegal_011_err", {31'h0, t_err}, 32'h1);
        do_req(1'b1, 3'b100, 32'h100, 32'h5A, t_rd, t_err, t_lat);
        do_req(1'b0, 3'b111, 32'h37, 32'h0, t_rd, t_err, t_lat);

        // Wrap at the top of the address space
        do_req(1'b0, 3'b010, 32'hFFFF_FFFE, 32'h0, t_rd, t_err, t_lat);
        do_req(1'b1, 3'b001, 32'hFFFF_FFFF, 32'h1234_5678, t_rd, t_err, t_lat);

        // Misaligned word on the strict instance: error, never a write
        @(negedge clk);
        req_valid2 = 1'b1; req_we2 = 1'b0; req_funct3_2 = 3'b010;
        req_addr2 = 32'h101; req_wdata2 = 32'h0000_00AB;
        @(posedge clk);
        #1 req_valid2 = 1'b0;
        @(negedge clk);
        chk("strict_acc0_addr", mem_addr2, 32'h100);
        chk("strict_acc0_be", {28'h0, byte_en2}, 32'hE);
        chk("strict_acc0_wdata", mem_wdata2, 32'h0000_AB00);
        chk("strict_ready_busy", {31'h0, req_ready2}, 32'h0);
        chk("strict_no_early_resp", {31'h0, resp_valid2}, 32'h0);
        @(negedge clk);
        chk("strict_resp_valid", {31'h0, resp_valid2}, 32'h1);
        chk("strict_resp_err", {31'h0, resp_err2}, 32'h1);
        chk("strict_resp_rdata", resp_rdata2, 32'h0);
        @(negedge clk);
        chk("strict_no_write", {31'h0, saw_wr2}, 32'h0);

        // Random requests over the whole address space
        for (int n = 0; n < 60; n++) begin
            do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom,
                   t_rd, t_err, t_lat);
        end

        // Whole-memory comparison against the byte model
        @(negedge clk);
        for (int w = 0; w < 64; w++) begin
            v = {ref_b[4*w+3], ref_b[4*w+2], ref_b[4*w+1], ref_b[4*w]};
            chk("final_mem", mem[w], v);
        end

        // Reset while the second half of a split store is on the bus
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
        req_addr = 32'h202; req_wdata = 32'h1122_3344;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rstmid_acc1_be", {28'h0, byte_en}, 32'h3);
        chk("rstmid_acc1_addr", mem_addr, 32'h204);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rstmid_mem_write", {31'h0, mem_write}, 32'h0);
        chk("rstmid_byte_en", {28'h0, byte_en}, 32'h0);
        chk("rstmid_req_ready", {31'h0, req_ready}, 32'h1);
        chk("rstmid_resp_valid", {31'h0, resp_valid}, 32'h0);
        @(negedge clk);
        chk("rstmid_no_late_resp", {31'h0, resp_valid}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
